// File: rtl/line_pacer.sv
// line_pacer: paces core video into the HDMI ring framebuffer, aligns frame starts and resyncs after errors
module line_pacer #(
  parameter int DEPTH_LINES = 32,
  parameter int HIGH_WM     = 24,
  parameter int HYST        = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sync_en,
  input  logic       core_frame_start,
  input  logic       core_line_done,
  input  logic       hdmi_frame_start,
  input  logic       hdmi_line_release,
  output logic       pause_core,
  output logic [5:0] occupancy,
  output logic       locked,
  output logic       overflow,
  output logic       underflow,
  output logic [7:0] resync_count
);
  typedef enum logic [1:0] {SEEK = 2'd0, ALIGN = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
  localparam logic [5:0] DEPTH = 6'(DEPTH_LINES);
  localparam logic [5:0] HI    = 6'(HIGH_WM);
  localparam logic [5:0] LO    = 6'(HIGH_WM - HYST);
  state_t      r_state;
  logic        r_pause;
  logic [5:0]  r_occ;
  logic        r_locked;
  logic        r_ovf;
  logic        r_unf;
  logic [7:0]  r_resync;
  logic        w_ovf;
  logic        w_unf;
  logic [5:0]  w_occ_next;
  logic [7:0]  w_resync_inc;
  function automatic logic pause_rule(input logic [5:0] occ, input logic cur);
    return (occ >= HI) ? 1'b1 : (occ <= LO) ? 1'b0 : cur;
  endfunction
  assign w_ovf        = core_line_done && !hdmi_line_release && (r_occ == DEPTH);
  assign w_unf        = hdmi_line_release && !core_line_done && (r_occ == 6'd0);
  assign w_occ_next   = r_occ + 6'(core_line_done) - 6'(hdmi_line_release);
  assign w_resync_inc = (r_resync == 8'hFF) ? r_resync : r_resync + 8'd1;
  assign pause_core   = r_pause;
  assign occupancy    = r_occ;
  assign locked       = r_locked;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  assign resync_count = r_resync;
  // pacing FSM: frame alignment, line accounting, pause hysteresis and error resync
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= SEEK;
      r_pause  <= 1'b0;
      r_occ    <= 6'd0;
      r_locked <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_resync <= 8'd0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (!sync_en) begin
        r_state  <= SEEK;
        r_occ    <= 6'd0;
        r_pause  <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          SEEK: begin
            r_occ   <= 6'd0;
            r_pause <= 1'b0;
            if (core_frame_start) r_state <= ALIGN;
          end
          ALIGN: if (core_line_done) begin
            r_occ   <= 6'd1;
            r_pause <= 1'b1;
            r_state <= HOLD;
          end
          HOLD: if (hdmi_frame_start) begin
            r_state  <= RUN;
            r_locked <= 1'b1;
            r_pause  <= pause_rule(r_occ, r_pause);
          end
          default: if (w_ovf || w_unf) begin
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
            r_resync <= w_resync_inc;
            r_state  <= SEEK;
            r_locked <= 1'b0;
            r_occ    <= 6'd0;
            r_pause  <= 1'b0;
          end else begin
            r_occ   <= w_occ_next;
            r_pause <= pause_rule(w_occ_next, r_pause);
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_line_pacer.sv
// tb_line_pacer: table vectors, directed corner sequences and randomized checks against a behavioural model
module tb_line_pacer;
  localparam int DEPTH = 32;
  localparam int HWM   = 24;
  localparam int HY    = 2;
  localparam int P_SEEK = 0, P_ALIGN = 1, P_HOLD = 2, P_RUN = 3;
  logic       clk = 0;
  logic       resetn = 0;
  logic       sync_en = 0;
  logic       core_frame_start = 0;
  logic       core_line_done = 0;
  logic       hdmi_frame_start = 0;
  logic       hdmi_line_release = 0;
  logic       pause_core;
  logic [5:0] occupancy;
  logic       locked;
  logic       overflow;
  logic       underflow;
  logic [7:0] resync_count;
  int n_pass = 0;
  int n_tot  = 0;
  bit g_chk  = 1;
  int m_ph, m_occ, m_rc;
  bit m_pause, m_ovf, m_unf;
  line_pacer dut (
    .clk(clk), .resetn(resetn), .sync_en(sync_en),
    .core_frame_start(core_frame_start), .core_line_done(core_line_done),
    .hdmi_frame_start(hdmi_frame_start), .hdmi_line_release(hdmi_line_release),
    .pause_core(pause_core), .occupancy(occupancy), .locked(locked),
    .overflow(overflow), .underflow(underflow), .resync_count(resync_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    int rep;
    bit fs, ld, hfs, rel, en;
    int occ;
    bit p, l, ov, un;
    int rc;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic model_reset();
    m_ph = P_SEEK; m_occ = 0; m_pause = 0; m_ovf = 0; m_unf = 0; m_rc = 0;
  endtask
  // behavioural reference: lines in buffer = written - released, errors when that leaves [0, DEPTH]
  task automatic model(input bit fs, input bit ld, input bit hfs, input bit rel, input bit en);
    int n;
    m_ovf = 0; m_unf = 0;
    if (!en) begin m_ph = P_SEEK; m_occ = 0; m_pause = 0; return; end
    if (m_ph == P_SEEK) begin
      if (fs) m_ph = P_ALIGN;
    end else if (m_ph == P_ALIGN) begin
      if (ld) begin m_ph = P_HOLD; m_occ = 1; m_pause = 1; end
    end else if (m_ph == P_HOLD) begin
      if (hfs) begin
        m_ph = P_RUN;
        if (m_occ >= HWM) m_pause = 1; else if (m_occ <= HWM - HY) m_pause = 0;
      end
    end else begin
      n = m_occ + int'(ld) - int'(rel);
      if (n > DEPTH || n < 0) begin
        m_ovf = (n > DEPTH); m_unf = (n < 0);
        m_rc = (m_rc < 255) ? m_rc + 1 : 255;
        m_ph = P_SEEK; m_occ = 0; m_pause = 0;
      end else begin
        m_occ = n;
        if (n >= HWM) m_pause = 1; else if (n <= HWM - HY) m_pause = 0;
      end
    end
  endtask
  task automatic cmp_model();
    chk("occupancy", occupancy, m_occ);
    chk("pause_core", pause_core, m_pause);
    chk("locked", locked, m_ph == P_RUN);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("resync_count", resync_count, m_rc);
  endtask
  task automatic step(input bit fs, input bit ld, input bit hfs, input bit rel);
    core_frame_start = fs; core_line_done = ld; hdmi_frame_start = hfs; hdmi_line_release = rel;
    @(posedge clk); #1;
    model(fs, ld, hfs, rel, sync_en);
    core_frame_start = 0; core_line_done = 0; hdmi_frame_start = 0; hdmi_line_release = 0;
    if (g_chk) cmp_model();
  endtask
  task automatic lock_up();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
  endtask
  initial begin
    int ld_pct, rel_pct;
    tbl[0]  = '{1, 0,0,0,0,1,  0, 0,0,0,0, 0};
    tbl[1]  = '{1, 1,0,0,0,1,  0, 0,0,0,0, 0};
    tbl[2]  = '{1, 0,1,0,0,1,  1, 1,0,0,0, 0};
    tbl[3]  = '{1, 0,0,0,1,1,  1, 1,0,0,0, 0};
    tbl[4]  = '{1, 0,1,0,0,1,  1, 1,0,0,0, 0};
    tbl[5]  = '{8, 0,0,0,0,1,  1, 1,0,0,0, 0};
    tbl[6]  = '{1, 0,0,1,0,1,  1, 0,1,0,0, 0};
    tbl[7]  = '{1, 0,1,0,1,1,  1, 0,1,0,0, 0};
    tbl[8]  = '{1, 0,0,0,1,1,  0, 0,1,0,0, 0};
    tbl[9]  = '{1, 0,1,0,1,1,  0, 0,1,0,0, 0};
    tbl[10] = '{1, 0,0,0,1,1,  0, 0,0,0,1, 1};
    tbl[11] = '{1, 0,0,0,0,1,  0, 0,0,0,0, 1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset occupancy", occupancy, 0);
    chk("reset pause", pause_core, 0);
    chk("reset locked", locked, 0);
    chk("reset resync", resync_count, 0);
    resetn = 1;
    g_chk = 0;
    foreach (tbl[k]) begin
      sync_en = tbl[k].en;
      for (int r = 0; r < tbl[k].rep; r++) begin
        step(tbl[k].fs, tbl[k].ld, tbl[k].hfs, tbl[k].rel);
        chk($sformatf("tbl%0d occupancy", k), occupancy, tbl[k].occ);
        chk($sformatf("tbl%0d pause", k), pause_core, tbl[k].p);
        chk($sformatf("tbl%0d locked", k), locked, tbl[k].l);
        chk($sformatf("tbl%0d overflow", k), overflow, tbl[k].ov);
        chk($sformatf("tbl%0d underflow", k), underflow, tbl[k].un);
        chk($sformatf("tbl%0d resync", k), resync_count, tbl[k].rc);
      end
    end
    g_chk = 1;
    lock_up();
    repeat (23) step(0, 1, 0, 0);
    chk("hwm occupancy", occupancy, 24);
    chk("hwm pause", pause_core, 1);
    step(0, 0, 0, 1);
    chk("hyst 23 pause", pause_core, 1);
    step(0, 0, 0, 1);
    chk("hyst 22 occupancy", occupancy, 22);
    chk("hyst 22 pause", pause_core, 0);
    repeat (10) step(0, 1, 0, 0);
    chk("full occupancy", occupancy, 32);
    step(0, 1, 0, 1);
    chk("full both occupancy", occupancy, 32);
    chk("full both overflow", overflow, 0);
    step(0, 1, 0, 0);
    chk("ovf pulse", overflow, 1);
    chk("ovf resync", resync_count, 2);
    chk("ovf locked", locked, 0);
    step(0, 0, 0, 0);
    chk("ovf single pulse", overflow, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    sync_en = 0;
    step(0, 0, 0, 0);
    chk("sync drop occupancy", occupancy, 0);
    chk("sync drop pause", pause_core, 0);
    chk("sync drop resync", resync_count, 2);
    sync_en = 1;
    g_chk = 0;
    for (int i = 0; i < 300; i++) begin
      lock_up();
      repeat (31) step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      chk("sat overflow", overflow, 1);
      chk("sat resync", resync_count, (i + 3 > 255) ? 255 : i + 3);
    end
    g_chk = 1;
    lock_up();
    repeat (5) step(0, 1, 0, 0);
    #3 resetn = 0;
    #1;
    model_reset();
    chk("async reset occupancy", occupancy, 0);
    chk("async reset pause", pause_core, 0);
    chk("async reset locked", locked, 0);
    chk("async reset resync", resync_count, 0);
    @(posedge clk);
    #2 resetn = 1;
    step(0, 0, 0, 0);
    ld_pct = 60; rel_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        ld_pct = $urandom_range(30, 90);
        rel_pct = $urandom_range(30, 90);
      end
      sync_en = ($urandom_range(0, 299) != 0);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 99) < ld_pct,
           $urandom_range(0, 14) == 0, $urandom_range(0, 99) < rel_pct);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
